// File: rtl/wisc_pkg.sv
// Shared WISC ISA definitions: opcode encoding and condition-flag bit positions.
package wisc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/wisc_alu_if.sv
// Execute-stage ALU bus: operands and opcode in, result and registered flags out.
interface wisc_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             en;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic [2:0]       flags;

    modport master (output en, opcode, in1, in2, input out, flags);
    modport slave  (input en, opcode, in1, in2, output out, flags);
endinterface

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: mode 0 = SLL, 1 = SRA, 2 = ROR.
module alu_shifter (
    input  logic [15:0] in1_i,
    input  logic [3:0]  shamt_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] res_o
);

    always_comb begin
        res_o = in1_i;
        case (mode_i)
            2'd0:    res_o = in1_i << shamt_i;
            2'd1:    res_o = $signed(in1_i) >>> shamt_i;
            // A left shift by 16 (shamt 0) yields zero, so the OR is just in1.
            2'd2:    res_o = (in1_i >> shamt_i) | (in1_i << (5'd16 - {1'b0, shamt_i}));
            default: res_o = in1_i;
        endcase
    end

endmodule

// File: rtl/wisc_alu.sv
// WISC 16-bit execute ALU: combinational result plus registered {Z, V, N} flags.
module wisc_alu
    import wisc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    wisc_alu_if.slave  bus
);

    opcode_t     op;
    logic [15:0] in1, in2;
    logic [15:0] add_raw, sub_raw, add_sat, sub_sat;
    logic        add_ovf, sub_ovf;
    logic [8:0]  t1, t2, t3;
    logic [15:0] red_res, padd_res, shift_res, res;
    logic [4:0]  lane;
    logic [2:0]  flags_q, flags_d;

    assign op  = opcode_t'(bus.opcode);
    assign in1 = bus.in1;
    assign in2 = bus.in2;

    // Shift mode is the low two opcode bits: SLL=4, SRA=5, ROR=6.
    alu_shifter u_shifter (
        .in1_i   (in1),
        .shamt_i (in2[3:0]),
        .mode_i  (bus.opcode[1:0]),
        .res_o   (shift_res)
    );

    always_comb begin
        add_raw = in1 + in2;
        sub_raw = in1 - in2;
        add_ovf = (in1[15] == in2[15]) && (add_raw[15] != in1[15]);
        sub_ovf = (in1[15] != in2[15]) && (sub_raw[15] != in1[15]);
        add_sat = add_ovf ? (in1[15] ? 16'h8000 : 16'h7FFF) : add_raw;
        sub_sat = sub_ovf ? (in1[15] ? 16'h8000 : 16'h7FFF) : sub_raw;

        t1      = {1'b0, in1[7:0]} + {1'b0, in2[7:0]};
        t2      = {1'b0, in1[15:8]} + {1'b0, in2[15:8]};
        t3      = t1 + t2;
        red_res = {{7{t3[8]}}, t3};

        lane     = '0;
        padd_res = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            lane = {in1[4*k+3], in1[4*k +: 4]} + {in2[4*k+3], in2[4*k +: 4]};
            if (lane[4] != lane[3])
                padd_res[4*k +: 4] = lane[4] ? 4'h8 : 4'h7;
            else
                padd_res[4*k +: 4] = lane[3:0];
        end
    end

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:                res = add_sat;
            OP_SUB:                res = sub_sat;
            OP_XOR:                res = in1 ^ in2;
            OP_RED:                res = red_res;
            OP_SLL, OP_SRA, OP_ROR: res = shift_res;
            OP_PADDSB:             res = padd_res;
            OP_LW, OP_SW:          res = add_raw;
            OP_LLB:                res = {in1[15:8], in2[7:0]};
            OP_LHB:                res = {in2[7:0], in1[7:0]};
            OP_PCS:                res = in1;
            default:               res = '0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        case (op)
            OP_ADD: flags_d = {(add_sat == '0), add_ovf, add_sat[15]};
            OP_SUB: flags_d = {(sub_sat == '0), sub_ovf, sub_sat[15]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLAG_Z] = (res == '0);
            default: flags_d = flags_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= '0;
        else if (bus.en)
            flags_q <= flags_d;
    end

    assign bus.out   = res;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_wisc_alu.sv
// Directed-vector and flag-sequence bench for wisc_alu.
module tb_wisc_alu;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    wisc_alu_if #(.WIDTH(16)) bus ();

    wisc_alu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.opcode = op;
        bus.in1    = a;
        bus.in2    = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One opcode across the four boundary operand pairs.
    task automatic add_row(input logic [3:0] op, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        add_vec(op, 16'h8000, 16'h0001, e0);
        add_vec(op, 16'h7FFF, 16'hFFFF, e1);
        add_vec(op, 16'hFFFF, 16'h8000, e2);
        add_vec(op, 16'h0001, 16'h7FFF, e3);
    endtask

    function automatic logic [15:0] shift_model(input logic [3:0] op, input logic [15:0] a,
                                                input logic [3:0] n);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < int'(n); i++) begin
            case (op)
                4'h4:    r = {r[14:0], 1'b0};
                4'h5:    r = {r[15], r[15:1]};
                default: r = {r[0], r[15:1]};
            endcase
        end
        return r;
    endfunction

    function automatic logic [15:0] padd_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int x, y, s;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            x = int'((a >> (4 * k)) & 16'hF);
            y = int'((b >> (4 * k)) & 16'hF);
            if (x > 7) x -= 16;
            if (y > 7) y -= 16;
            s = x + y;
            if (s > 7) s = 7;
            if (s < -8) s = -8;
            r = r | (16'(s & 15) << (4 * k));
        end
        return r;
    endfunction

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [3:0]  nonflag_ops[10];

        bus.en = 1'b1;
        drive(4'h2, 16'h5555, 16'h5555);

        // Reset wins over en even though XOR would set Z.
        tick();
        chk("reset_flags", {13'd0, bus.flags}, 16'h0000);
        rst = 1'b0;
        chk("xor_zero_out", bus.out, 16'h0000);
        tick();
        chk("xor_zero_flags", {13'd0, bus.flags}, 16'h0004);

        drive(4'h0, 16'h7FFF, 16'h0001);
        chk("add_sat_out", bus.out, 16'h7FFF);
        tick();
        chk("add_sat_flags", {13'd0, bus.flags}, 16'h0002);

        drive(4'h1, 16'h8000, 16'h0001);
        chk("sub_sat_out", bus.out, 16'h8000);
        tick();
        chk("sub_sat_flags", {13'd0, bus.flags}, 16'h0003);

        bus.en = 1'b0;
        drive(4'h2, 16'h0000, 16'h0000);
        tick();
        chk("stall_hold_flags", {13'd0, bus.flags}, 16'h0003);
        bus.en = 1'b1;

        drive(4'h0, 16'hFFFF, 16'h0001);
        tick();
        chk("add_zero_flags", {13'd0, bus.flags}, 16'h0004);

        drive(4'h1, 16'h8000, 16'h0001);
        tick();
        drive(4'h2, 16'h0001, 16'h0000);
        tick();
        chk("xor_z_only_flags", {13'd0, bus.flags}, 16'h0003);
        drive(4'h4, 16'h8000, 16'h0001);
        tick();
        chk("sll_z_only_flags", {13'd0, bus.flags}, 16'h0007);

        nonflag_ops = '{4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        foreach (nonflag_ops[i]) begin
            drive(nonflag_ops[i], 16'h0000, 16'h0000);
            tick();
            chk($sformatf("nonflag_hold_op%h", nonflag_ops[i]), {13'd0, bus.flags}, 16'h0007);
        end

        bus.en = 1'b0;
        add_vec(4'h3, 16'h8000, 16'h0001, 16'h0081);
        add_vec(4'h3, 16'hFFFF, 16'h7FFF, 16'hFF7C);
        add_vec(4'h5, 16'h8000, 16'h0004, 16'hF800);
        add_vec(4'h6, 16'h0001, 16'h0001, 16'h8000);
        add_vec(4'h4, 16'h7FFF, 16'h0001, 16'hFFFE);
        add_vec(4'h4, 16'h0001, 16'hFFF3, 16'h0008);
        add_vec(4'h5, 16'h8000, 16'hFFF3, 16'hF000);
        add_vec(4'h7, 16'h7777, 16'h1111, 16'h7777);
        add_vec(4'h7, 16'h8888, 16'hFFFF, 16'h8888);
        add_vec(4'h7, 16'h1234, 16'h1111, 16'h2345);
        add_row(4'h0, 16'h8001, 16'h7FFE, 16'h8000, 16'h7FFF);
        add_row(4'h1, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8002);
        add_row(4'h2, 16'h8001, 16'h8000, 16'h7FFF, 16'h7FFE);
        add_row(4'h3, 16'h0081, 16'hFF7C, 16'h007E, 16'hFF7F);
        add_row(4'h4, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000);
        add_row(4'h5, 16'hC000, 16'h0000, 16'hFFFF, 16'h0000);
        add_row(4'h6, 16'h4000, 16'hFFFE, 16'hFFFF, 16'h0002);
        add_row(4'h7, 16'h8001, 16'h6EEE, 16'h8FFF, 16'h7FF0);
        add_row(4'h8, 16'h8001, 16'h7FFE, 16'h7FFF, 16'h8000);
        add_row(4'h9, 16'h8001, 16'h7FFE, 16'h7FFF, 16'h8000);
        add_row(4'hA, 16'h8001, 16'h7FFF, 16'hFF00, 16'h00FF);
        add_row(4'hB, 16'h0100, 16'hFFFF, 16'h00FF, 16'hFF01);
        add_row(4'hC, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add_row(4'hD, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add_row(4'hE, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001);
        add_row(4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_op%h_%h_%h", i, vecs[i].op, vecs[i].a, vecs[i].b),
                bus.out, vecs[i].exp);
        end
        tick();
        chk("sweep_flags_hold", {13'd0, bus.flags}, 16'h0007);

        for (int i = 0; i < 150; i++) begin
            op = 4'(4 + (i % 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            drive(op, a, b);
            chk($sformatf("rshift_op%h_%h_%h", op, a, b), bus.out, shift_model(op, a, b[3:0]));
        end

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            drive(4'h7, a, b);
            chk($sformatf("rpaddsb_%h_%h", a, b), bus.out, padd_model(a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
